// File: rtl/bp_cce_hybrid_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bp_cce_hybrid_req_arbiter
// Brief    : Whole-message arbiter merging pending-queue replays (valid->yumi)
//            and new LCE requests (ready&valid) into one BedRock burst stream.
//            Optional fairness counter enabled by BP_CCE_HYBRID_ARB_FAIR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bp_cce_hybrid_req_arbiter #(
  parameter int lce_req_msg_header_width_lp = 64,
  parameter int lce_data_width_p            = 64,
  parameter int max_pend_grants_p           = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,

  input  logic [lce_req_msg_header_width_lp-1:0] pend_header_i,
  input  logic                                   pend_header_v_i,
  output logic                                   pend_header_yumi_o,
  input  logic                                   pend_has_data_i,
  input  logic [lce_data_width_p-1:0]            pend_data_i,
  input  logic                                   pend_data_v_i,
  output logic                                   pend_data_yumi_o,
  input  logic                                   pend_last_i,

  input  logic [lce_req_msg_header_width_lp-1:0] new_header_i,
  input  logic                                   new_header_v_i,
  output logic                                   new_header_ready_and_o,
  input  logic                                   new_has_data_i,
  input  logic [lce_data_width_p-1:0]            new_data_i,
  input  logic                                   new_data_v_i,
  output logic                                   new_data_ready_and_o,
  input  logic                                   new_last_i,

  output logic [lce_req_msg_header_width_lp-1:0] lce_req_header_o,
  output logic                                   lce_req_header_v_o,
  input  logic                                   lce_req_header_ready_and_i,
  output logic                                   lce_req_has_data_o,
  output logic [lce_data_width_p-1:0]            lce_req_data_o,
  output logic                                   lce_req_data_v_o,
  input  logic                                   lce_req_data_ready_and_i,
  output logic                                   lce_req_last_o,

  output logic                                   src_pend_o,
  output logic                                   busy_o
);

  typedef enum logic [0:0] {
    e_ready = 1'b0,
    e_data  = 1'b1
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic r_lock_v;
  logic r_lock_pend;
  logic r_src_pend;
  logic w_sel_pend;
  logic w_use_pend;
  logic w_fair_new;
  logic w_hdr_hs;
  logic w_data_hs;

  if (max_pend_grants_p < 1) begin : g_bad_cfg
    $error("max_pend_grants_p must be >= 1");
  end

`ifdef BP_CCE_HYBRID_ARB_FAIR_EN
  localparam int c_cnt_w = $clog2(max_pend_grants_p + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(max_pend_grants_p);

  logic [c_cnt_w-1:0] r_pend_cnt;

  assign w_fair_new = new_header_v_i & (r_pend_cnt == c_cnt_max);

  // Counts pending grants taken while a new header was left waiting.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pend_cnt <= '0;
    end else if (w_hdr_hs && !w_sel_pend) begin
      r_pend_cnt <= '0;
    end else if (w_hdr_hs && new_header_v_i && (r_pend_cnt != c_cnt_max)) begin
      r_pend_cnt <= r_pend_cnt + 1'b1;
    end
  end
`else
  assign w_fair_new = 1'b0;
`endif

  always_comb begin
    if (r_lock_v) begin
      w_sel_pend = r_lock_pend;
    end else if (w_fair_new) begin
      w_sel_pend = 1'b0;
    end else begin
      w_sel_pend = pend_header_v_i;
    end
  end

  assign w_use_pend         = (r_state == e_data) ? r_src_pend : w_sel_pend;
  assign lce_req_header_o   = w_use_pend ? pend_header_i   : new_header_i;
  assign lce_req_has_data_o = w_use_pend ? pend_has_data_i : new_has_data_i;
  assign lce_req_data_o     = w_use_pend ? pend_data_i     : new_data_i;
  assign lce_req_last_o     = w_use_pend ? pend_last_i     : new_last_i;
  assign src_pend_o         = w_use_pend;
  assign busy_o             = (r_state == e_data);

  always_comb begin
    w_state_next           = r_state;
    lce_req_header_v_o     = 1'b0;
    pend_header_yumi_o     = 1'b0;
    new_header_ready_and_o = 1'b0;
    lce_req_data_v_o       = 1'b0;
    pend_data_yumi_o       = 1'b0;
    new_data_ready_and_o   = 1'b0;
    w_hdr_hs               = 1'b0;
    w_data_hs              = 1'b0;
    if (!reset_i) begin
      case (r_state)
        e_ready: begin
          lce_req_header_v_o     = w_sel_pend ? pend_header_v_i : new_header_v_i;
          w_hdr_hs               = lce_req_header_v_o & lce_req_header_ready_and_i;
          pend_header_yumi_o     = w_sel_pend & w_hdr_hs;
          new_header_ready_and_o = ~w_sel_pend & lce_req_header_ready_and_i;
          if (w_hdr_hs && lce_req_has_data_o) begin
            w_state_next = e_data;
          end
        end
        e_data: begin
          lce_req_data_v_o     = r_src_pend ? pend_data_v_i : new_data_v_i;
          w_data_hs            = lce_req_data_v_o & lce_req_data_ready_and_i;
          pend_data_yumi_o     = r_src_pend & w_data_hs;
          new_data_ready_and_o = ~r_src_pend & lce_req_data_ready_and_i;
          if (w_data_hs && lce_req_last_o) begin
            w_state_next = e_ready;
          end
        end
        default: w_state_next = e_ready;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= e_ready;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A presented but stalled header pins the selection until it is accepted.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_lock_v    <= 1'b0;
      r_lock_pend <= 1'b0;
      r_src_pend  <= 1'b0;
    end else if (w_hdr_hs) begin
      r_lock_v   <= 1'b0;
      r_src_pend <= w_sel_pend;
    end else if (lce_req_header_v_o) begin
      r_lock_v    <= 1'b1;
      r_lock_pend <= w_sel_pend;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bp_cce_hybrid_req_arbiter.sv
`default_nettype none
// Testbench for bp_cce_hybrid_req_arbiter: directed table, corner sequences
// and randomized traffic checked against a message-level reference model.
module tb_bp_cce_hybrid_req_arbiter;

  localparam int HW   = 16;
  localparam int DW   = 16;
  localparam int MAXG = 2;
`ifdef BP_CCE_HYBRID_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam logic [HW-1:0] PH = 16'hA5A5;
  localparam logic [HW-1:0] NH = 16'h5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [HW-1:0] ph, nh, hdr_o;
  logic [DW-1:0] pd, nd, data_o;
  logic pv, phd, pdv, plast, nv, nhd, ndv, nlast, hrdy, drdy;
  logic pyumi, pdyumi, nrdy, ndrdy, hv_o, hasd_o, dv_o, last_o, src_o, busy_o;

  bp_cce_hybrid_req_arbiter #(
    .lce_req_msg_header_width_lp(HW),
    .lce_data_width_p           (DW),
    .max_pend_grants_p          (MAXG)
  ) dut (
    .clk_i                     (clk),
    .reset_i                   (reset),
    .pend_header_i             (ph),
    .pend_header_v_i           (pv),
    .pend_header_yumi_o        (pyumi),
    .pend_has_data_i           (phd),
    .pend_data_i               (pd),
    .pend_data_v_i             (pdv),
    .pend_data_yumi_o          (pdyumi),
    .pend_last_i               (plast),
    .new_header_i              (nh),
    .new_header_v_i            (nv),
    .new_header_ready_and_o    (nrdy),
    .new_has_data_i            (nhd),
    .new_data_i                (nd),
    .new_data_v_i              (ndv),
    .new_data_ready_and_o      (ndrdy),
    .new_last_i                (nlast),
    .lce_req_header_o          (hdr_o),
    .lce_req_header_v_o        (hv_o),
    .lce_req_header_ready_and_i(hrdy),
    .lce_req_has_data_o        (hasd_o),
    .lce_req_data_o            (data_o),
    .lce_req_data_v_o          (dv_o),
    .lce_req_data_ready_and_i  (drdy),
    .lce_req_last_o            (last_o),
    .src_pend_o                (src_o),
    .busy_o                    (busy_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Message-level model: who owns the channel for a burst, who is holding
  // a stalled header, and how many pending grants a waiting new header has seen.
  int m_burst;  // 0 none, 1 pending burst, 2 new burst
  int m_hold;   // 0 none, 1 pending header held, 2 new header held
  int m_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; pv = 1'b0; phd = 1'b0; pdv = 1'b0; plast = 1'b0;
    nv = 1'b0; nhd = 1'b0; ndv = 1'b0; nlast = 1'b0; hrdy = 1'b0; drdy = 1'b0;
    ph = PH; nh = NH; pd = 16'h1111; nd = 16'h2222;
  endtask

  // Inputs are already applied (just after a negedge); check, update model,
  // then advance past the next posedge to the following negedge.
  task automatic cycle();
    bit p;
    bit e_hv, e_py, e_nr, e_dv, e_pdy, e_ndr;
    #1;
    p = 1'b0;
    e_hv = 0; e_py = 0; e_nr = 0; e_dv = 0; e_pdy = 0; e_ndr = 0;
    if (!reset) begin
      if (m_burst != 0) begin
        p     = (m_burst == 1);
        e_dv  = p ? pdv : ndv;
        e_pdy = p & pdv & drdy;
        e_ndr = !p & drdy;
      end else begin
        if (m_hold != 0)                      p = (m_hold == 1);
        else if (FAIR && nv && m_wait >= MAXG) p = 1'b0;
        else                                  p = pv;
        e_hv = p ? pv : nv;
        e_py = p & pv & hrdy;
        e_nr = !p & hrdy;
      end
      chk("src_pend", src_o, p);
    end
    chk("header_v", hv_o, e_hv);
    chk("pend_header_yumi", pyumi, e_py);
    chk("new_header_ready", nrdy, e_nr);
    chk("data_v", dv_o, e_dv);
    chk("pend_data_yumi", pdyumi, e_pdy);
    chk("new_data_ready", ndrdy, e_ndr);
    chk("busy", busy_o, m_burst != 0);
    if (e_hv) begin
      chk("header", hdr_o, p ? ph : nh);
      chk("has_data", hasd_o, p ? phd : nhd);
    end
    if (e_dv) begin
      chk("data", data_o, p ? pd : nd);
      chk("last", last_o, p ? plast : nlast);
    end
    if (reset) begin
      m_burst = 0; m_hold = 0; m_wait = 0;
    end else if (m_burst != 0) begin
      if (e_dv && drdy && (p ? plast : nlast)) m_burst = 0;
    end else if (e_hv && hrdy) begin
      m_hold = 0;
      if (p ? phd : nhd) m_burst = p ? 1 : 2;
      if (p && nv)       m_wait = (m_wait + 1 > MAXG) ? MAXG : m_wait + 1;
      if (!p)            m_wait = 0;
    end else if (e_hv) begin
      m_hold = p ? 1 : 2;
    end
    @(negedge clk);
    cyc++;
  endtask

  typedef struct packed {
    logic pv, phd, nv, hr, pdv, plast, dr;
    logic e_hv, e_py, e_nr, e_dv, e_pdy, e_busy, e_src;
  } vec_t;

  vec_t vt[13];
  int   fair_src[6];

  initial begin
    m_burst = 0; m_hold = 0; m_wait = 0;
    // pend, pend, new header-only; pend 4-beat burst with new waiting;
    // new held under backpressure while pending rises.
    vt[0]  = '{1,0,1,1,0,0,1, 1,1,0,0,0,0,1};
    vt[1]  = '{1,0,1,1,0,0,1, 1,1,0,0,0,0,1};
    vt[2]  = '{0,0,1,1,0,0,1, 1,0,1,0,0,0,0};
    vt[3]  = '{1,1,1,1,0,0,1, 1,1,0,0,0,0,1};
    vt[4]  = '{0,0,1,1,1,0,1, 0,0,0,1,1,1,1};
    vt[5]  = '{0,0,1,1,1,0,1, 0,0,0,1,1,1,1};
    vt[6]  = '{0,0,1,1,1,0,1, 0,0,0,1,1,1,1};
    vt[7]  = '{0,0,1,1,1,1,1, 0,0,0,1,1,1,1};
    vt[8]  = '{0,0,1,1,0,0,1, 1,0,1,0,0,0,0};
    vt[9]  = '{0,0,1,0,0,0,1, 1,0,0,0,0,0,0};
    vt[10] = '{1,0,1,0,0,0,1, 1,0,0,0,0,0,0};
    vt[11] = '{1,0,1,0,0,0,1, 1,0,0,0,0,0,0};
    vt[12] = '{1,0,1,1,0,0,1, 1,0,1,0,0,0,0};
    fair_src = '{1, 1, 0, 1, 1, 0};

    idle_inputs();
    @(negedge clk);
    reset = 1'b1; pv = 1'b1; nv = 1'b1; hrdy = 1'b1; drdy = 1'b1;
    cycle();
    cycle();

    idle_inputs();
    for (int i = 0; i < 13; i++) begin
      pv = vt[i].pv; phd = vt[i].phd; nv = vt[i].nv; hrdy = vt[i].hr;
      pdv = vt[i].pdv; plast = vt[i].plast; drdy = vt[i].dr;
      #1;
      chk($sformatf("vec%0d_hv", i),   hv_o,   vt[i].e_hv);
      chk($sformatf("vec%0d_py", i),   pyumi,  vt[i].e_py);
      chk($sformatf("vec%0d_nr", i),   nrdy,   vt[i].e_nr);
      chk($sformatf("vec%0d_dv", i),   dv_o,   vt[i].e_dv);
      chk($sformatf("vec%0d_pdy", i),  pdyumi, vt[i].e_pdy);
      chk($sformatf("vec%0d_busy", i), busy_o, vt[i].e_busy);
      chk($sformatf("vec%0d_src", i),  src_o,  vt[i].e_src);
      cycle();
    end

    // Fairness order with pending continuously valid.
    idle_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0; pv = 1'b1; nv = 1'b1; hrdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
`ifdef BP_CCE_HYBRID_ARB_FAIR_EN
      chk($sformatf("fair_order%0d", i), src_o, fair_src[i]);
`else
      chk($sformatf("strict_order%0d", i), src_o, 1);
      chk($sformatf("strict_nrdy%0d", i), nrdy, 0);
`endif
      cycle();
    end

    // Reset on beat 2 of a 4-beat new burst.
    idle_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0; nv = 1'b1; nhd = 1'b1; hrdy = 1'b1;
    cycle();
    idle_inputs();
    ndv = 1'b1; drdy = 1'b1; nd = 16'h0B01;
    cycle();
    reset = 1'b1; nd = 16'h0B02;
    #1;
    chk("rst_mid_ndr", ndrdy, 0);
    chk("rst_mid_dv", dv_o, 0);
    cycle();
    reset = 1'b0;
    #1;
    chk("post_rst_busy", busy_o, 0);
    chk("post_rst_dv", dv_o, 0);
    chk("post_rst_ndr", ndrdy, 0);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(63) == 0);
      pv    = $urandom_range(1); phd = $urandom_range(1);
      nv    = $urandom_range(1); nhd = $urandom_range(1);
      pdv   = $urandom_range(1); plast = ($urandom_range(3) == 0);
      ndv   = $urandom_range(1); nlast = ($urandom_range(3) == 0);
      hrdy  = ($urandom_range(3) != 0);
      drdy  = ($urandom_range(3) != 0);
      ph    = HW'($urandom); nh = HW'($urandom);
      pd    = DW'($urandom); nd = DW'($urandom);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
